guitar_event_arbiter: RTL and testbench

Sits between the raw guitar-controller pins and the processor's external-input register-file port. Synchronises and debounces both players' fret and strum lines, and turns each strum into a discrete event carrying the fret pattern. It arbitrates round-robin between the two players and presents one event word at a time to the processor, holding it until the processor acknowledges it. This replaces the direct combinational fret/strum mapping into the external-input word.

---
 rtl/guitar_pkg.sv | 39 +++
 rtl/guitar_event_arbiter_debouncer.sv | 55 +++++
 rtl/guitar_event_arbiter.sv | 174 +++++++++++++++++
 tb/tb_guitar_event_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/guitar_pkg.sv
// guitar_pkg
//   Shared definitions for the guitar event arbiter: event word field
//   positions, the output FSM state type, player identifiers and a helper
//   that assembles one event word.
package guitar_pkg;

  localparam int FRET1_LSB = 0;
  localparam int FRET2_LSB = 3;
  localparam int VALID_BIT = 6;
  localparam int PID_BIT   = 7;
  localparam int SEQ_LSB   = 8;
  localparam int SEQ_W     = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    GAP     = 2'd2
  } arb_state_t;

  localparam logic P1 = 1'b0;
  localparam logic P2 = 1'b1;

  // Player-1 frets land in [2:0], player-2 frets in [5:3]; the other
  // player's field stays zero so the word lines up with the legacy
  // guitar_in bit positions.
  function automatic logic [31:0] make_event(input logic       pid,
                                             input logic [2:0] frets,
                                             input logic [SEQ_W-1:0] seq);
    logic [31:0] w;
    w = '0;
    if (pid == P1) w[FRET1_LSB +: 3] = frets;
    else           w[FRET2_LSB +: 3] = frets;
    w[VALID_BIT]         = 1'b1;
    w[PID_BIT]           = pid;
    w[SEQ_LSB +: SEQ_W]  = seq;
    return w;
  endfunction

endpackage

// File: rtl/guitar_event_arbiter_debouncer.sv
// input_debouncer
//   One raw input line: 2-flop synchroniser followed by a stability
//   counter. The debounced output only follows the synchronised value
//   after it has differed from the current output for DEBOUNCE_CYCLES
//   consecutive cycles.
// Ports:
//   clock  in  system clock
//   reset  in  asynchronous, active-high reset
//   i_raw  in  raw (asynchronous) input line
//   o_db   out debounced line (optionally inverted after the synchroniser)
module input_debouncer #(
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter int   CNT_W           = 20,
  parameter logic INVERT          = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic i_raw,
  output logic o_db
);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_db;
  logic [CNT_W-1:0] r_cnt;
  logic             w_synced;
  logic [CNT_W-1:0] w_cnt_inc;

  // Active-low lines are flipped here so everything downstream is 1=active.
  assign w_synced  = r_sync2 ^ INVERT;
  assign w_cnt_inc = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_db    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (w_synced == r_db) begin
        r_cnt <= '0;
      end else if (w_cnt_inc == CNT_W'(DEBOUNCE_CYCLES)) begin
        r_db  <= w_synced;
        r_cnt <= '0;
      end else begin
        r_cnt <= w_cnt_inc;
      end
    end
  end

  assign o_db = r_db;

endmodule

// File: rtl/guitar_event_arbiter.sv
// guitar_event_arbiter
//   Debounces both players' fret/strum lines, turns each debounced strum
//   rising edge into a one-deep pending event per player (fret pattern
//   captured at the edge), and presents events one at a time to the
//   processor with round-robin arbitration between the players.
//
//   Handshake: event_valid (== event_word[6]) rises when an event is loaded
//   and the word is held unchanged while valid is high. A one-cycle ack
//   while valid is high consumes it; valid then drops and stays low for at
//   least one cycle before the next event. ack while valid is low is ignored.
// Ports:
//   clock       in  system clock
//   reset       in  asynchronous, active-high reset
//   p1_frets_n  in  player-1 frets, raw, active-low
//   p1_strum    in  player-1 strum, raw, active-high
//   p2_frets_n  in  player-2 frets, raw, active-low
//   p2_strum    in  player-2 strum, raw, active-high
//   ack         in  processor consumed the presented event
//   event_word  out event word to the register file
//   event_valid out event_word holds an unconsumed event
//   drop_count  out saturating count of events lost to overflow
module guitar_event_arbiter
  import guitar_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 20
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  p1_frets_n,
  input  logic        p1_strum,
  input  logic [2:0]  p2_frets_n,
  input  logic        p2_strum,
  input  logic        ack,
  output logic [31:0] event_word,
  output logic        event_valid,
  output logic [7:0]  drop_count
);

  logic [2:0]  w_p1_frets;
  logic [2:0]  w_p2_frets;
  logic        w_p1_strum;
  logic        w_p2_strum;

  for (genvar gi = 0; gi < 3; gi++) begin : g_frets
    input_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W), .INVERT(1'b1)
    ) u_p1_fret (
      .clock(clock), .reset(reset), .i_raw(p1_frets_n[gi]), .o_db(w_p1_frets[gi])
    );
    input_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W), .INVERT(1'b1)
    ) u_p2_fret (
      .clock(clock), .reset(reset), .i_raw(p2_frets_n[gi]), .o_db(w_p2_frets[gi])
    );
  end

  input_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W), .INVERT(1'b0)
  ) u_p1_strum (
    .clock(clock), .reset(reset), .i_raw(p1_strum), .o_db(w_p1_strum)
  );
  input_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W), .INVERT(1'b0)
  ) u_p2_strum (
    .clock(clock), .reset(reset), .i_raw(p2_strum), .o_db(w_p2_strum)
  );

  // ---------------------------------------------------------------------
  // Strum edge detection and per-player pending slot (index 0 = P1)
  // ---------------------------------------------------------------------
  logic [1:0]  r_strum_prev;
  logic [1:0]  r_pending;
  logic [2:0]  r_p1_cap;
  logic [2:0]  r_p2_cap;
  logic [7:0]  r_drop_count;
  logic [1:0]  w_rise;
  logic [1:0]  w_clear;
  logic [1:0]  w_drop;
  logic [8:0]  w_drop_sum;

  arb_state_t  r_state;
  logic [31:0] r_event_word;
  logic        r_rr_last;
  logic [SEQ_W-1:0] r_seq;

  logic        w_grant_any;
  logic        w_grant_pid;
  logic [2:0]  w_grant_frets;

  assign w_rise = {w_p2_strum & ~r_strum_prev[1], w_p1_strum & ~r_strum_prev[0]};

  // A grant empties the slot in the same cycle, so a simultaneous edge for
  // that player finds room and is kept rather than dropped.
  assign w_clear = {w_grant_any & (w_grant_pid == P2), w_grant_any & (w_grant_pid == P1)};
  assign w_drop  = w_rise & r_pending & ~w_clear;

  assign w_drop_sum = {1'b0, r_drop_count} + {8'd0, w_drop[0]} + {8'd0, w_drop[1]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_strum_prev <= 2'b00;
      r_pending    <= 2'b00;
      r_p1_cap     <= 3'b000;
      r_p2_cap     <= 3'b000;
      r_drop_count <= 8'd0;
    end else begin
      r_strum_prev <= {w_p2_strum, w_p1_strum};
      r_pending    <= (r_pending & ~w_clear) | (w_rise & ~w_drop);
      if (w_rise[0] && !w_drop[0]) r_p1_cap <= w_p1_frets;
      if (w_rise[1] && !w_drop[1]) r_p2_cap <= w_p2_frets;
      r_drop_count <= (w_drop_sum > 9'd255) ? 8'hFF : w_drop_sum[7:0];
    end
  end

  // ---------------------------------------------------------------------
  // Round-robin grant, only evaluated in IDLE
  // ---------------------------------------------------------------------
  always_comb begin
    w_grant_any   = 1'b0;
    w_grant_pid   = P1;
    w_grant_frets = 3'b000;
    if (r_state == IDLE) begin
      if (r_pending[0] && r_pending[1]) begin
        w_grant_any = 1'b1;
        w_grant_pid = (r_rr_last == P2) ? P1 : P2;
      end else if (r_pending[0]) begin
        w_grant_any = 1'b1;
        w_grant_pid = P1;
      end else if (r_pending[1]) begin
        w_grant_any = 1'b1;
        w_grant_pid = P2;
      end
      w_grant_frets = (w_grant_pid == P1) ? r_p1_cap : r_p2_cap;
    end
  end

  // ---------------------------------------------------------------------
  // Output FSM with registered event word
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_event_word <= '0;
      r_rr_last    <= P2;
      r_seq        <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_any) begin
            r_event_word <= make_event(w_grant_pid, w_grant_frets, r_seq + 8'd1);
            r_seq        <= r_seq + 8'd1;
            r_rr_last    <= w_grant_pid;
            r_state      <= PRESENT;
          end
        end
        PRESENT: begin
          if (ack) begin
            r_event_word[VALID_BIT] <= 1'b0;
            r_state                 <= GAP;
          end
        end
        // Guaranteed low cycle so a polling loop sees valid fall between events.
        GAP:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign event_word  = r_event_word;
  assign event_valid = r_event_word[VALID_BIT];
  assign drop_count  = r_drop_count;

endmodule

// File: tb/tb_guitar_event_arbiter.sv
module tb_guitar_event_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  p1_frets_n;
  logic        p1_strum;
  logic [2:0]  p2_frets_n;
  logic        p2_strum;
  logic        ack;
  logic [31:0] event_word;
  logic        event_valid;
  logic [7:0]  drop_count;

  int n_tests = 0;
  int n_fail  = 0;

  guitar_event_arbiter #(.DEBOUNCE_CYCLES(4), .CNT_W(20)) dut (
    .clock(clock), .reset(reset),
    .p1_frets_n(p1_frets_n), .p1_strum(p1_strum),
    .p2_frets_n(p2_frets_n), .p2_strum(p2_strum),
    .ack(ack), .event_word(event_word), .event_valid(event_valid),
    .drop_count(drop_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    p1_frets_n = 3'b111;
    p2_frets_n = 3'b111;
    p1_strum   = 1'b0;
    p2_strum   = 1'b0;
    ack        = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic ack_pulse();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  // Ticks until event_valid is seen; lat = tick index, 0 when it never came.
  task automatic wait_valid(input int budget, output int lat);
    lat = 0;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (event_valid) begin
        lat = i;
        return;
      end
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        pid;
    logic [2:0]  frets_n;
    int          hold;
    int          exp_lat;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int lat;
    logic [31:0] word;

    // pid, raw frets (active-low), strum high cycles, expected latency, word
    vecs[0] = '{1'b0, 3'b101, 10, 8, 32'h0000_0142};
    vecs[1] = '{1'b1, 3'b111,  3, 0, 32'h0000_0000};
    vecs[2] = '{1'b1, 3'b011,  6, 8, 32'h0000_02E0};
    vecs[3] = '{1'b0, 3'b111,  8, 8, 32'h0000_0340};
    vecs[4] = '{1'b1, 3'b000,  5, 8, 32'h0000_04F8};
    vecs[5] = '{1'b0, 3'b110,  4, 8, 32'h0000_0541};
    vecs[6] = '{1'b0, 3'b000,  1, 0, 32'h0000_0000};

    reset      = 1'b1;
    p1_frets_n = 3'b111;
    p2_frets_n = 3'b111;
    p1_strum   = 1'b0;
    p2_strum   = 1'b0;
    ack        = 1'b0;
    repeat (2) tick();
    check("reset_word", event_word, 32'h0);
    check("reset_valid", {31'd0, event_valid}, 32'h0);
    check("reset_drop", {24'd0, drop_count}, 32'h0);
    reset = 1'b0;
    tick();

    // ---- table: single-player strums, glitches and boundary holds ----
    for (int v = 0; v < 7; v++) begin
      if (vecs[v].pid == 1'b0) p1_frets_n = vecs[v].frets_n;
      else                     p2_frets_n = vecs[v].frets_n;
      repeat (8) tick();
      if (vecs[v].pid == 1'b0) p1_strum = 1'b1;
      else                     p2_strum = 1'b1;
      lat  = 0;
      word = 32'h0;
      for (int i = 1; i <= 20; i++) begin
        tick();
        if (lat == 0 && event_valid) begin
          lat  = i;
          word = event_word;
        end
        if (i == vecs[v].hold) begin
          p1_strum = 1'b0;
          p2_strum = 1'b0;
        end
      end
      check($sformatf("vec%0d_latency", v), lat, vecs[v].exp_lat);
      if (vecs[v].exp_lat != 0) begin
        check($sformatf("vec%0d_word", v), word, vecs[v].exp_word);
        check($sformatf("vec%0d_held", v), event_word, vecs[v].exp_word);
        ack_pulse();
        check($sformatf("vec%0d_gap_valid", v), {31'd0, event_valid}, 32'h0);
        check($sformatf("vec%0d_gap_word", v), event_word, vecs[v].exp_word & ~32'h40);
        tick();
        check($sformatf("vec%0d_idle_valid", v), {31'd0, event_valid}, 32'h0);
      end else begin
        check($sformatf("vec%0d_no_event", v), {31'd0, event_valid}, 32'h0);
      end
      check($sformatf("vec%0d_drop", v), {24'd0, drop_count}, 32'h0);
    end

    // ---- simultaneous strums after reset: P1 first, then P2 ----
    do_reset();
    p1_frets_n = 3'b110;
    p2_frets_n = 3'b101;
    repeat (8) tick();
    p1_strum = 1'b1;
    p2_strum = 1'b1;
    wait_valid(12, lat);
    check("tie_lat", lat, 8);
    check("tie_p1_word", event_word, 32'h0000_0141);
    repeat (3) tick();
    p1_strum = 1'b0;
    p2_strum = 1'b0;
    check("tie_p1_held", event_word, 32'h0000_0141);
    ack_pulse();
    wait_valid(5, lat);
    check("tie_p2_lat", lat, 2);
    check("tie_p2_word", event_word, 32'h0000_02D0);
    ack_pulse();

    // ---- overflow: three P1 strums with the first un-acked ----
    do_reset();
    repeat (8) tick();
    for (int k = 0; k < 3; k++) begin
      p1_strum = 1'b1;
      repeat (6) tick();
      p1_strum = 1'b0;
      repeat (8) tick();
    end
    check("ovf_first_word", event_word, 32'h0000_0140);
    check("ovf_drop", {24'd0, drop_count}, 32'h1);
    ack_pulse();
    wait_valid(5, lat);
    check("ovf_second_lat", lat, 2);
    check("ovf_second_word", event_word, 32'h0000_0240);
    ack_pulse();
    wait_valid(30, lat);
    check("ovf_no_third", lat, 0);
    check("ovf_drop_after", {24'd0, drop_count}, 32'h1);

    // ---- reset mid-operation: P1 presented, P2 pending, drop_count=1 ----
    p1_strum = 1'b1;
    wait_valid(12, lat);
    check("rst_p1_word", event_word, 32'h0000_0340);
    p1_strum = 1'b0;
    p2_strum = 1'b1;
    repeat (10) tick();
    reset = 1'b1;
    #1;
    check("rst_async_valid", {31'd0, event_valid}, 32'h0);
    tick();
    check("rst_word", event_word, 32'h0);
    check("rst_drop", {24'd0, drop_count}, 32'h0);
    p2_strum = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    wait_valid(30, lat);
    check("rst_no_stale", lat, 0);
    p1_strum = 1'b1;
    wait_valid(12, lat);
    check("rst_seq_restart", event_word, 32'h0000_0140);
    p1_strum = 1'b0;
    ack_pulse();
    repeat (8) tick();

    // ---- ack outside PRESENT is ignored ----
    ack_pulse();
    tick();
    check("idle_ack_valid", {31'd0, event_valid}, 32'h0);
    p1_strum = 1'b1;
    p2_strum = 1'b1;
    wait_valid(12, lat);
    // rr_last is P1 after the previous event, so P2 wins this tie.
    check("rr_p2_first", event_word, 32'h0000_02C0);
    p1_strum = 1'b0;
    p2_strum = 1'b0;
    ack = 1'b1;
    tick();
    check("hold_ack_gap", {31'd0, event_valid}, 32'h0);
    tick();
    check("hold_ack_idle", {31'd0, event_valid}, 32'h0);
    ack = 1'b0;
    tick();
    check("hold_ack_next_valid", {31'd0, event_valid}, 32'h1);
    repeat (3) tick();
    check("hold_ack_next_word", event_word, 32'h0000_0340);
    ack_pulse();
    tick();
    check("final_valid", {31'd0, event_valid}, 32'h0);
    check("final_drop", {24'd0, drop_count}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
